// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode/issue stage: widths, ALU op codes,
// opcode constants, the ID/EX bundle type and sign-extension helpers.
package id_stage_pkg;

    localparam int DSIZE = 16;
    localparam int NREG  = 16;
    localparam int AW    = 4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SRA = 3'b110,
        ALU_RL  = 3'b111
    } alu_op_e;

    localparam logic [3:0] OPC_LW  = 4'b1000;
    localparam logic [3:0] OPC_SW  = 4'b1001;
    localparam logic [3:0] OPC_LLB = 4'b1010;

    typedef struct packed {
        logic             valid;
        alu_op_e          op;
        logic [DSIZE-1:0] a;
        logic [DSIZE-1:0] b;
        logic [3:0]       imm;
        logic [AW-1:0]    rd;
        logic [AW-1:0]    rs;
        logic [AW-1:0]    rt;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic [DSIZE-1:0] store_data;
    } idex_t;

    function automatic logic [DSIZE-1:0] sext4(input logic [3:0] v);
        return {{(DSIZE-4){v[3]}}, v};
    endfunction

    function automatic logic [DSIZE-1:0] sext8(input logic [7:0] v);
        return {{(DSIZE-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 16x16 register file: two asynchronous read ports, one synchronous write
// port, r0 hardwired to zero, write-through bypass, cleared by reset.
module regfile
    import id_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [AW-1:0]    raddr1_i,
    input  logic [AW-1:0]    raddr2_i,
    output logic [DSIZE-1:0] rdata1_o,
    output logic [DSIZE-1:0] rdata2_o
);

    logic [DSIZE-1:0] mem_q [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            // One flop row per register; r0 never accepts a write.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (we_i && (waddr_i == AW'(gi)) && (gi != 0)) begin
                    mem_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    // Read ports: r0 is zero, a same-cycle write to the read address bypasses.
    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        rdata2_o = mem_q[raddr2_i];
        if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
        if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
        if (raddr1_i == '0) rdata1_o = '0;
        if (raddr2_i == '0) rdata2_o = '0;
    end

endmodule

// File: rtl/id_stage.sv
// Decode/issue stage: decodes one instruction per cycle, reads operands,
// detects load-use hazards and registers the ID/EX bundle for the ALU.
module id_stage
    import id_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_inst,
    input  logic             flush,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_addr,
    input  logic [DSIZE-1:0] wb_data,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [2:0]       ex_op,
    output logic [DSIZE-1:0] ex_a,
    output logic [DSIZE-1:0] ex_b,
    output logic [3:0]       ex_imm,
    output logic [AW-1:0]    ex_rd,
    output logic [AW-1:0]    ex_rs_addr,
    output logic [AW-1:0]    ex_rt_addr,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [DSIZE-1:0] ex_store_data
);

    logic [3:0]       opc;
    logic [AW-1:0]    rd_f, rs_f, rt_f;
    logic [AW-1:0]    p2_addr;
    logic             p2_used;
    logic [DSIZE-1:0] rdata1, rdata2;
    idex_t            dec;
    idex_t            bundle_d, bundle_q;

    assign opc  = in_inst[15:12];
    assign rd_f = in_inst[11:8];
    assign rs_f = in_inst[7:4];
    assign rt_f = in_inst[3:0];

    // SW reads its store value through port 2, so that port addresses rd.
    assign p2_addr = (opc == OPC_SW) ? rd_f : rt_f;
    assign p2_used = ((opc[3] == 1'b0) && (opc[2] == 1'b0)) || (opc == OPC_SW);

    regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_we),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (rs_f),
        .raddr2_i (p2_addr),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    // Instruction decode into a candidate ID/EX bundle.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.rd    = rd_f;
        dec.rs    = rs_f;
        dec.rt    = p2_addr;
        if (opc[3] == 1'b0) begin
            dec.op        = alu_op_e'(opc[2:0]);
            dec.a         = rdata1;
            dec.reg_write = 1'b1;
            if (opc[2] == 1'b0) dec.b   = rdata2;
            else                dec.imm = rt_f;
        end else begin
            case (opc)
                OPC_LW: begin
                    dec.a         = rdata1;
                    dec.b         = sext4(rt_f);
                    dec.mem_read  = 1'b1;
                    dec.reg_write = 1'b1;
                end
                OPC_SW: begin
                    dec.a          = rdata1;
                    dec.b          = sext4(rt_f);
                    dec.store_data = rdata2;
                    dec.mem_write  = 1'b1;
                end
                OPC_LLB: begin
                    dec.b         = sext8(in_inst[7:0]);
                    dec.reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Load-use hazard against the load currently in EX; flush and reset win.
    assign id_stall = !rst && !flush && in_valid &&
                      bundle_q.valid && bundle_q.mem_read && (bundle_q.rd != '0) &&
                      ((bundle_q.rd == rs_f) || (p2_used && (bundle_q.rd == p2_addr)));

    // Next bundle: flush and stall insert bubbles, otherwise take the decode.
    always_comb begin
        bundle_d = '0;
        if (!flush && !id_stall && in_valid) bundle_d = dec;
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bundle_q <= '0;
        else     bundle_q <= bundle_d;
    end

    assign ex_valid      = bundle_q.valid;
    assign ex_op         = bundle_q.op;
    assign ex_a          = bundle_q.a;
    assign ex_b          = bundle_q.b;
    assign ex_imm        = bundle_q.imm;
    assign ex_rd         = bundle_q.rd;
    assign ex_rs_addr    = bundle_q.rs;
    assign ex_rt_addr    = bundle_q.rt;
    assign ex_reg_write  = bundle_q.reg_write;
    assign ex_mem_read   = bundle_q.mem_read;
    assign ex_mem_write  = bundle_q.mem_write;
    assign ex_store_data = bundle_q.store_data;

endmodule

// File: doc/id_stage.md
# id_stage

Decode/issue stage feeding the 16-bit ALU. Accepts one instruction per cycle from fetch, reads operands from an internal 16×16 register file, and presents a registered ID/EX bundle (op, A, B, shift imm, control bits) to the ALU the following cycle. Detects load-use hazards and stalls fetch for one bubble. Honours a branch flush.

## Interface
- `DSIZE`, 16: datapath and instruction width.
- `NREG`, 16: register count; r0 reads as zero.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch presents a valid instruction.
- `in_inst`  in  16  instruction word.
- `flush`  in  1  squash the instruction currently in ID.
- `wb_we`  in  1  writeback enable.
- `wb_addr`  in  4  writeback register.
- `wb_data`  in  16  writeback value.
- `id_stall`  out  1  combinational; fetch must hold `in_inst` when high.
- `ex_valid`  out  1  ID/EX bundle valid.
- `ex_op`  out  3  ALU op: ADD 000, SUB 001, AND 010, OR 011, SLL 100, SRL 101, SRA 110, RL 111.
- `ex_a`, `ex_b`  out  16  ALU operands.
- `ex_imm`  out  4  shift amount.
- `ex_rd`  out  4  destination register.
- `ex_rs_addr`, `ex_rt_addr`  out  4  source addresses, for downstream forwarding.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1  control.
- `ex_store_data`  out  16  store value.

## Operation
- Fields: opc=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm4=[3:0], imm8=[7:0].
- opc 0xxx, R-type: op=opc[2:0]. A=R[rs]. B=R[rt] for ops 000–011. For ops 100–111, imm=imm4 and B=0. reg_write=1.
- 1000 LW rd,rs,imm4: op=ADD, A=R[rs], B=sext(imm4), mem_read=1, reg_write=1.
- 1001 SW rd,rs,imm4: op=ADD, A=R[rs], B=sext(imm4), store_data=R[rd], mem_write=1. Read port 2 addresses rd.
- 1010 LLB rd,imm8: op=ADD, A=0, B=sext(imm8), reg_write=1.
- 1011–1111: NOP. `ex_valid`=1 with all write/mem controls 0.
- Register file:
  - two asynchronous read ports, one synchronous write.
  - Writes to r0 are ignored; reads of r0 return 0.
  - Same-cycle write/read of the same nonzero register returns `wb_data` (bypass).
- Load-use hazard: `id_stall` = in_valid & ex_valid & ex_mem_read & ex_rd≠0 & (ex_rd==rs, or ex_rd==port-2 address when that port is used).
- Port 2 is used by R-type ops 000–011 (rt) and by SW (rd).
- Update priority at each edge:
  1. rst: all outputs 0.
  2. flush: bubble (all outputs 0).
  3. id_stall: bubble; fetch holds the instruction.
  4. in_valid: load the decoded bundle.
  5. otherwise: bubble.
- `flush` suppresses `id_stall`: `id_stall` is low whenever `flush` is high.

## Timing
- Latency: instruction sampled at edge N appears on `ex_*` after edge N; the ALU consumes it at edge N+1.
- Throughput: 1 instruction/cycle; exactly one bubble per load-use hazard.
- Reset:
  - Every `ex_*` output is 0, and `ex_op`=000.
  - All registers are cleared.
  - `id_stall` is 0 while `rst` is high.
- Reset asserted mid-stall discards the held instruction. Fetch re-supplies it.
- Simultaneous `flush` and hazard: flush wins and produces no stall cycle.
- Writeback to a register being read in the same cycle: the new value is captured (bypass).

## Structure
- The shared defines package holds:
  - `DSIZE`
  - ALU op codes (`ADD`…`RL`)
  - opcode constants (`OPC_LW`, `OPC_SW`, `OPC_LLB`)
  - the register-address width
- Sub-module `regfile`: 16×16, 2R1W, r0 hardwired, write-through bypass, async reset clear.
- The top level contains the decode logic, hazard compare, and ID/EX register.

## Test plan
- Reset, then `wb` writes r1=0x0005 and r2=0x0003. Issue SUB r3,r1,r2 (0x1312) -> next cycle `ex_op`=001, `ex_a`=0x0005, `ex_b`=0x0003, `ex_rd`=3, `ex_reg_write`=1.
- Issue SRA r4,r1,#2 (0x6412) -> `ex_op`=110, `ex_imm`=2, `ex_b`=0.
- Issue LW r5,r1,#-1 (0x851F), then ADD r6,r5,r2 (0x0652) -> `id_stall`=1 for one cycle, one bubble (`ex_valid`=0), then the ADD issues with `ex_rs_addr`=5.
- `wb_we`=1 with `wb_addr`=7, `wb_data`=0xBEEF in the same cycle as issuing OR r8,r7,r0 (0x3870) -> `ex_a`=0xBEEF, `ex_b`=0.
- `flush`=1 together with an LW→use hazard -> outputs are a bubble and `id_stall`=0. LLB r9,#0x80 (0xA980) -> `ex_b`=0xFF80, `ex_a`=0.
- Write to r0 (`wb_addr`=0, `wb_data`=0xFFFF), then ADD r1,r0,r0 -> `ex_a`=`ex_b`=0. Asserting `rst` mid-stream clears all outputs immediately (asynchronous).
